// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes the ALU function.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               iord,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_control,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_reg, state_next;
    ctrl_t  ctrl_reg, ctrl_out;

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMREAD: c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = FETCH;
        if (reset) begin
            case (state_reg)
                FETCH: state_next = DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_RTYPE:     state_next = EXECUTE;
                        OP_BEQ:       state_next = BRANCH;
                        OP_ADDI:      state_next = ADDIEX;
                        OP_J:         state_next = JUMP;
                        default:      state_next = FETCH;
                    endcase
                end
                MEMADR:  state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD: state_next = MEMWB;
                EXECUTE: state_next = ALUWB;
                ADDIEX:  state_next = ADDIWB;
                default: state_next = FETCH;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        state_reg <= state_next;
        ctrl_reg  <= decode_state(state_next);
    end

    // Reset overrides the registered outputs so no write can leak out in a reset cycle.
    always_comb begin
        ctrl_out = ctrl_reg;
        if (!reset) begin
            ctrl_out           = decode_state(FETCH);
            ctrl_out.pc_write  = 1'b0;
            ctrl_out.ir_write  = 1'b0;
            ctrl_out.mem_write = 1'b0;
            ctrl_out.reg_write = 1'b0;
        end
    end

    always_comb begin
        alu_control = 3'b010;
        case (ctrl_out.alu_op)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    assign pc_write   = ctrl_out.pc_write | (ctrl_out.branch & zero);
    assign ir_write   = ctrl_out.ir_write;
    assign mem_write  = ctrl_out.mem_write;
    assign reg_write  = ctrl_out.reg_write;
    assign iord       = ctrl_out.iord;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign pc_src     = ctrl_out.pc_src;
    assign state      = STATE_W'(state_reg);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction stream against an instruction-level model of the
// multicycle control unit: expected state paths and per-step control values.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_write, ir_write, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_control(alu_control), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       iord, reg_dst, mem_to_reg, alu_src_a;
        logic       ir_write, mem_write, reg_write, pcw, branch;
        logic [1:0] src_b, pc_src, aop;
    } exp_t;

    // Control values required in each step of an instruction.
    function automatic exp_t step_outputs(input int s);
        exp_t e;
        e = '0;
        case (s)
            0:  begin e.src_b = 2'b01; e.ir_write = 1; e.pcw = 1; end
            1:  e.src_b = 2'b11;
            2, 9: begin e.alu_src_a = 1; e.src_b = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
            5:  begin e.iord = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 1; e.aop = 2'b10; end
            7:  begin e.reg_dst = 1; e.reg_write = 1; end
            8:  begin e.alu_src_a = 1; e.aop = 2'b01; e.pc_src = 2'b01; e.branch = 1; end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pcw = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] alu_fn(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    int m_state;
    int pend[$];

    // Steps following FETCH for each opcode.
    task automatic plan_instr(input logic [5:0] o);
        pend.delete();
        pend.push_back(1);
        case (o)
            6'b100011: begin pend.push_back(2); pend.push_back(3); pend.push_back(4); end
            6'b101011: begin pend.push_back(2); pend.push_back(5); end
            6'b000000: begin pend.push_back(6); pend.push_back(7); end
            6'b000100: pend.push_back(8);
            6'b001000: begin pend.push_back(9); pend.push_back(10); end
            6'b000010: pend.push_back(11);
            default: ;
        endcase
    endtask

    logic [5:0] op_tab [8];
    logic [5:0] fn_tab [6];
    int  hold_cnt = 0;
    bit  did_s3 = 0;
    exp_t e;

    initial begin
        op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                   6'b001000, 6'b000010, 6'b111111, 6'b000001};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_state = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 0) begin
                reset = 1'b1;
            end else if (hold_cnt > 0) begin
                reset = 1'b0;
                hold_cnt--;
            end else if (!did_s3 && m_state == 3) begin
                reset = 1'b0;
                did_s3 = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                hold_cnt = $urandom_range(0, 2);
            end else begin
                reset = 1'b1;
            end

            if (reset && m_state == 0) begin
                op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 7)];
                funct = fn_tab[$urandom_range(0, 5)];
                $display("cycle %0d: issue op=%b funct=%b", cyc, op, funct);
            end
            zero = 1'($urandom_range(0, 1));

            @(negedge clk);
            e = step_outputs(reset ? m_state : 0);
            if (!reset) begin
                e.ir_write = 0; e.mem_write = 0; e.reg_write = 0; e.pcw = 0;
            end
            check("state", state, m_state);
            check("pc_write", pc_write, e.pcw | (e.branch & zero));
            check("ir_write", ir_write, e.ir_write);
            check("mem_write", mem_write, e.mem_write);
            check("reg_write", reg_write, e.reg_write);
            check("iord", iord, e.iord);
            check("reg_dst", reg_dst, e.reg_dst);
            check("mem_to_reg", mem_to_reg, e.mem_to_reg);
            check("alu_src_a", alu_src_a, e.alu_src_a);
            check("alu_src_b", alu_src_b, e.src_b);
            check("pc_src", pc_src, e.pc_src);
            check("alu_control", alu_control, alu_fn(e.aop, funct));

            if (!reset) begin
                pend.delete();
                m_state = 0;
            end else begin
                if (m_state == 0) plan_instr(op);
                m_state = (pend.size() > 0) ? pend.pop_front() : 0;
            end

            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
